cmos_frame_crop: RTL and testbench

//  Crops a programmable window out of the 16-bit CMOS pixel stream and forwards it to the

---
 rtl/cmos_frame_crop.sv | 203 ++++++++++++++++++++
 tb/tb_cmos_frame_crop.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/cmos_frame_crop.sv
// -----------------------------------------------------------------------------
// cmos_frame_crop
//   Crops a programmable window out of the 16-bit CMOS pixel stream coming from
//   cmos_8_16bit and forwards it to the video_timing_data FIFO write port.
//   Runs entirely in the pclk domain. Output stays suppressed until a full frame
//   boundary has been seen, so a partial frame after reset never reaches the FIFO.
//
//   Build option: CMOS_FRAME_CROP_PATTERN_EN
//     defined   -> data_o carries 8 vertical RGB565 colour bars across the window
//     undefined -> data_o is the registered input pixel (no bar logic built)
//
// Ports
//   pclk       in   pixel clock, sole clock
//   rst        in   synchronous reset, active-high
//   vs_i       in   sensor vsync (polarity set by VS_POL)
//   de_i       in   pixel valid, one pixel per high cycle
//   data_i     in   RGB565 pixel
//   vs_o       out  vs_i delayed one cycle
//   de_o       out  pixel valid inside the crop window (1-cycle latency)
//   data_o     out  pixel registered together with de_o
//   locked     out  high while the FSM is in ACTIVE
//   frame_err  out  sticky: some frame ended short of V_START+V_ACTIVE lines
//   line_cnt   out  lines counted in the last completed frame (saturating)
//
// State  | meaning
// -------+----------------------------------------------------------------
// WAIT_VS| after reset; nothing forwarded until vsync is seen asserted
// SYNC   | inside vsync blanking; x/y held at zero
// ACTIVE | frame in progress; counting pixels/lines, window forwarded
// -----------------------------------------------------------------------------
module cmos_frame_crop #(
    parameter int H_START  = 0,
    parameter int H_ACTIVE = 480,
    parameter int V_START  = 0,
    parameter int V_ACTIVE = 272,
    parameter bit VS_POL   = 1'b1,
    parameter int CW       = 12
) (
    input  logic          pclk,
    input  logic          rst,
    input  logic          vs_i,
    input  logic          de_i,
    input  logic [15:0]   data_i,
    output logic          vs_o,
    output logic          de_o,
    output logic [15:0]   data_o,
    output logic          locked,
    output logic          frame_err,
    output logic [CW-1:0] line_cnt
);

    typedef enum logic [1:0] {
        WAIT_VS = 2'd0,
        SYNC    = 2'd1,
        ACTIVE  = 2'd2
    } state_t;

    // Window bounds held at CW+1 bits so START+ACTIVE never overflows.
    localparam logic [CW:0]   LP_H_LO  = (CW+1)'(H_START);
    localparam logic [CW:0]   LP_H_ACT = (CW+1)'(H_ACTIVE);
    localparam logic [CW:0]   LP_V_LO  = (CW+1)'(V_START);
    localparam logic [CW:0]   LP_V_ACT = (CW+1)'(V_ACTIVE);
    localparam logic [CW:0]   LP_V_END = (CW+1)'(V_START + V_ACTIVE);
    localparam logic [CW-1:0] LP_MAX   = {CW{1'b1}};
    localparam logic [CW-1:0] LP_ONE   = CW'(1);

    state_t          r_state;
    logic [CW-1:0]   r_x;
    logic [CW-1:0]   r_y;
    logic            r_vs_act_d;
    logic            r_de_d;
    logic            r_vs_o;
    logic            r_de_o;
    logic [15:0]     r_data_o;
    logic            r_locked;
    logic            r_frame_err;
    logic [CW-1:0]   r_line_cnt;

    logic            w_vs_act;
    logic            w_vs_start;
    logic            w_de_fall;
    logic [CW:0]     w_xrel;
    logic [CW:0]     w_yrel;
    logic            w_win;
    logic [CW-1:0]   w_x_inc;
    logic [CW-1:0]   w_y_inc;
    logic            w_short;
    logic [15:0]     w_pix;

    assign w_vs_act   = vs_i ^ ~VS_POL;
    assign w_vs_start = w_vs_act & ~r_vs_act_d;
    assign w_de_fall  = ~de_i & r_de_d;

    // Offset into the window. When the counter is below START the subtraction
    // wraps to a value above 2^CW, which can never be < ACTIVE, so a single
    // unsigned compare covers both bounds.
    assign w_xrel = {1'b0, r_x} - LP_H_LO;
    assign w_yrel = {1'b0, r_y} - LP_V_LO;
    assign w_win  = (w_xrel < LP_H_ACT) && (w_yrel < LP_V_ACT);

    assign w_x_inc = (r_x == LP_MAX) ? r_x : r_x + LP_ONE;
    assign w_y_inc = (r_y == LP_MAX) ? r_y : r_y + LP_ONE;
    assign w_short = ({1'b0, r_y} < LP_V_END);

`ifdef CMOS_FRAME_CROP_PATTERN_EN
    localparam logic [CW+3:0] LP_H_ACT_W = (CW+4)'(H_ACTIVE);
    localparam logic [CW+3:0] LP_BAR_MAX = (CW+4)'(7);

    logic [CW+3:0] w_bar_num;
    logic [CW+3:0] w_bar_q;
    logic [2:0]    w_bar_idx;

    assign w_bar_num = {w_xrel, 3'b000};
    assign w_bar_q   = w_bar_num / LP_H_ACT_W;
    // Outside the window the quotient is meaningless; clamp keeps it in range.
    assign w_bar_idx = (w_bar_q > LP_BAR_MAX) ? 3'd7 : w_bar_q[2:0];

    always_comb begin
        w_pix = 16'h0000;
        case (w_bar_idx)
            3'd0:    w_pix = 16'hFFFF;
            3'd1:    w_pix = 16'hFFE0;
            3'd2:    w_pix = 16'h07FF;
            3'd3:    w_pix = 16'h07E0;
            3'd4:    w_pix = 16'hF81F;
            3'd5:    w_pix = 16'hF800;
            3'd6:    w_pix = 16'h001F;
            default: w_pix = 16'h0000;
        endcase
    end
`else
    assign w_pix = data_i;
`endif

    always_ff @(posedge pclk) begin
        if (rst) begin
            r_state     <= WAIT_VS;
            r_x         <= '0;
            r_y         <= '0;
            r_vs_act_d  <= 1'b0;
            r_de_d      <= 1'b0;
            r_vs_o      <= 1'b0;
            r_de_o      <= 1'b0;
            r_data_o    <= 16'h0000;
            r_locked    <= 1'b0;
            r_frame_err <= 1'b0;
            r_line_cnt  <= '0;
        end else begin
            r_vs_act_d <= w_vs_act;
            r_de_d     <= de_i;
            r_vs_o     <= vs_i;

            if (de_i) begin
                r_data_o <= w_pix;
            end

            // A pixel coinciding with the vsync edge belongs to no frame.
            r_de_o <= de_i & w_win & (r_state == ACTIVE) & ~w_vs_start;

            case (r_state)
                WAIT_VS: begin
                    r_locked <= 1'b0;
                    if (w_vs_act) begin
                        r_state <= SYNC;
                    end
                end
                SYNC: begin
                    r_x <= '0;
                    r_y <= '0;
                    if (!w_vs_act) begin
                        r_state  <= ACTIVE;
                        r_locked <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (w_vs_start) begin
                        r_state     <= SYNC;
                        r_locked    <= 1'b0;
                        r_line_cnt  <= r_y;
                        r_frame_err <= r_frame_err | w_short;
                    end else if (w_de_fall) begin
                        r_x <= '0;
                        r_y <= w_y_inc;
                    end else if (de_i) begin
                        r_x <= w_x_inc;
                    end
                end
                default: begin
                    r_state  <= WAIT_VS;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    assign vs_o      = r_vs_o;
    assign de_o      = r_de_o;
    assign data_o    = r_data_o;
    assign locked    = r_locked;
    assign frame_err = r_frame_err;
    assign line_cnt  = r_line_cnt;

endmodule

// File: tb/tb_cmos_frame_crop.sv
// Bench for cmos_frame_crop with a 32x2 window at (16,4) and 6-bit counters.
// Inputs change on the falling edge; outputs are read on the next falling
// edge, i.e. one rising edge later, which is the designed latency.
module tb_cmos_frame_crop;

    localparam int CW = 6;

    logic          pclk;
    logic          rst;
    logic          vs_i;
    logic          de_i;
    logic [15:0]   data_i;
    logic          vs_o;
    logic          de_o;
    logic [15:0]   data_o;
    logic          locked;
    logic          frame_err;
    logic [CW-1:0] line_cnt;

    int            n_chk;
    int            n_pass;
    int            n_de;
    bit            g_act;
    logic [15:0]   bars [8];

    cmos_frame_crop #(
        .H_START (16),
        .H_ACTIVE(32),
        .V_START (4),
        .V_ACTIVE(2),
        .VS_POL  (1'b1),
        .CW      (CW)
    ) u_dut (
        .pclk     (pclk),
        .rst      (rst),
        .vs_i     (vs_i),
        .de_i     (de_i),
        .data_i   (data_i),
        .vs_o     (vs_o),
        .de_o     (de_o),
        .data_o   (data_o),
        .locked   (locked),
        .frame_err(frame_err),
        .line_cnt (line_cnt)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic pix(input logic vs, input logic de, input logic [15:0] d);
        vs_i   = vs;
        de_i   = de;
        data_i = d;
        @(negedge pclk);
    endtask

    function automatic int sat(input int v);
        return (v > 63) ? 63 : v;
    endfunction

    function automatic bit in_win(input int x, input int y);
        int xs;
        int ys;
        xs = sat(x);
        ys = sat(y);
        return (xs >= 16) && (xs < 48) && (ys >= 4) && (ys < 6);
    endfunction

    function automatic logic [15:0] exp_pix(input int x, input logic [15:0] d);
`ifdef CMOS_FRAME_CROP_PATTERN_EN
        int xs;
        xs = sat(x);
        return bars[(xs - 16) * 8 / 32];
`else
        return d;
`endif
    endfunction

    // Drives a vsync pulse plus back porch and checks the frame summary that
    // the preceding vsync edge latched.
    task automatic vs_pulse(input int exp_lc, input bit exp_fe);
        pix(1'b1, 1'b0, 16'h0);
        chk("vs_o_hi", vs_o, 1);
        chk("de_in_vs", de_o, 0);
        pix(1'b1, 1'b0, 16'h0);
        pix(1'b1, 1'b0, 16'h0);
        chk("unlocked_in_vs", locked, 0);
        pix(1'b0, 1'b0, 16'h0);
        chk("vs_o_lo", vs_o, 0);
        pix(1'b0, 1'b0, 16'h0);
        chk("locked", locked, 1);
        chk("line_cnt", line_cnt, exp_lc);
        chk("frame_err", frame_err, exp_fe);
        g_act = 1'b1;
    endtask

    // w x h pixels with 4-cycle horizontal blanking. If (cx,cy) is reached,
    // that pixel is driven together with the vsync rising edge and the task
    // returns.
    task automatic lines(input int w, input int h, input int cy, input int cx, input int exp_n);
        logic [15:0] d;
        logic [15:0] last;
        bit          ew;
        n_de = 0;
        last = 16'h0;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                d = {8'(y), 8'(x)};
                if (y == cy && x == cx) begin
                    pix(1'b1, 1'b1, d);
                    chk("collision_de", de_o, 0);
                    chk("frame_de_count", n_de, exp_n);
                    return;
                end
                pix(1'b0, 1'b1, d);
                ew = g_act && in_win(x, y);
                chk("de_o", de_o, ew);
                if (ew) chk("data_o", data_o, exp_pix(x, d));
                if (de_o) n_de++;
                last = d;
            end
            for (int b = 0; b < 4; b++) begin
                pix(1'b0, 1'b0, 16'h0);
                chk("blank_de", de_o, 0);
            end
`ifndef CMOS_FRAME_CROP_PATTERN_EN
            chk("data_hold", data_o, last);
`endif
        end
        chk("frame_de_count", n_de, exp_n);
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        n_de   = 0;
        g_act  = 1'b0;
        bars[0] = 16'hFFFF; bars[1] = 16'hFFE0; bars[2] = 16'h07FF; bars[3] = 16'h07E0;
        bars[4] = 16'hF81F; bars[5] = 16'hF800; bars[6] = 16'h001F; bars[7] = 16'h0000;

        // Reset held with busy inputs: every output must sit at its reset value.
        rst    = 1'b1;
        vs_i   = 1'b1;
        de_i   = 1'b1;
        data_i = 16'h1234;
        repeat (3) @(negedge pclk);
        chk("rst_vs_o", vs_o, 0);
        chk("rst_de_o", de_o, 0);
        chk("rst_data_o", data_o, 0);
        chk("rst_locked", locked, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_line_cnt", line_cnt, 0);

        // Released mid-frame with de toggling and no vsync: nothing forwarded.
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            pix(1'b0, 1'(i % 2), 16'(i));
            chk("pre_sync_de", de_o, 0);
        end
        chk("pre_sync_locked", locked, 0);

        // Two full frames.
        vs_pulse(0, 1'b0);
        lines(64, 8, -1, -1, 64);
        vs_pulse(8, 1'b0);
        lines(64, 8, -1, -1, 64);
        vs_pulse(8, 1'b0);

        // Short frame sets the sticky error; it survives a good frame.
        lines(64, 3, -1, -1, 0);
        vs_pulse(3, 1'b1);
        lines(64, 8, -1, -1, 64);
        vs_pulse(8, 1'b1);

        // Pixel at (20,4) arrives with the vsync edge: dropped, line_cnt = 4.
        lines(64, 8, 4, 20, 4);
        vs_pulse(4, 1'b1);
        // Next frame must start from x=y=0.
        lines(64, 8, -1, -1, 64);
        vs_pulse(8, 1'b1);

        // Over-long lines and over-tall frame: counters saturate at 63.
        lines(100, 70, -1, -1, 64);
        vs_pulse(63, 1'b1);

        // Reset in the middle of a frame.
        lines(64, 3, -1, -1, 0);
        rst = 1'b1;
        pix(1'b0, 1'b1, 16'hABCD);
        chk("midrst_vs_o", vs_o, 0);
        chk("midrst_de_o", de_o, 0);
        chk("midrst_data_o", data_o, 0);
        chk("midrst_locked", locked, 0);
        chk("midrst_frame_err", frame_err, 0);
        chk("midrst_line_cnt", line_cnt, 0);
        rst   = 1'b0;
        g_act = 1'b0;
        lines(64, 8, -1, -1, 0);
        chk("midrst_unlocked", locked, 0);
        vs_pulse(0, 1'b0);
        lines(64, 8, -1, -1, 64);
        vs_pulse(8, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
